uart_8250_rx: RTL

- Serial receive datapath of the uart_8250 peripheral. Sits directly downstream of the divisor-latch baud generator, which supplies a 16x oversample enable.
- Deserialises RXD into RBR data plus LSR status bits (DR, OE, PE, FE, BI).
- The register file reads RBR/LSR from this block and pulses pop/clear strobes back on Wishbone reads.

---
 rtl/uart_8250_pkg.sv | 33 +++
 rtl/uart_8250_rx_fifo.sv | 55 +++++
 rtl/uart_8250_rx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_8250_pkg.sv
// uart_8250 shared definitions: LCR field positions, receive FSM encoding,
// oversample mid-point helper and LSR bit indices.
package uart_8250_pkg;

    // LCR field positions (only [5:0] reach the receiver)
    localparam int LCR_WLS_LSB = 0;
    localparam int LCR_WLS_MSB = 1;
    localparam int LCR_STB     = 2;
    localparam int LCR_PEN     = 3;
    localparam int LCR_EPS     = 4;
    localparam int LCR_STICK   = 5;

    // Receive FSM encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;
    localparam logic [2:0] ST_BRKWAIT = 3'd5;

    // LSR bit indices as seen by the register file
    localparam int LSR_DR = 0;
    localparam int LSR_OE = 1;
    localparam int LSR_PE = 2;
    localparam int LSR_FE = 3;
    localparam int LSR_BI = 4;

    // Tick index of the middle of the start bit, counted from the first low tick
    function automatic int rx_mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_8250_rx_fifo.sv
// Synchronous receive FIFO for uart_8250_rx (used when UART_RX_FIFO_EN is set).
// A push while full is accepted only if a pop happens in the same cycle.
module uart_8250_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write
    // NOTE: the array is deliberately not reset; an entry is only read after it is written, and a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_8250_rx.sv
// uart_8250 serial receiver: synchronises RXD, oversamples it with the baud
// generator's tick, and produces RBR data and LSR status (DR, OE, PE, FE, BI).
// Optional build macro UART_RX_FIFO_EN replaces the single holding register
// with a FIFO_DEPTH-entry receive FIFO.
module uart_8250_rx
    import uart_8250_pkg::*;
#(
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_FIFO_EN
    ,
    parameter int FIFO_DEPTH = 16
`endif
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       baud_tick_i,
    input  logic       rxd_i,
    input  logic [5:0] lcr_i,
    input  logic       rbr_pop_i,
    input  logic       lsr_clr_i,
    output logic [7:0] rbr_o,
    output logic       dr_o,
    output logic       oe_o,
    output logic       pe_o,
    output logic       fe_o,
    output logic       bi_o,
    output logic       rx_busy_o
);

    localparam int               CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(rx_mid_tick(OVERSAMPLE));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

    logic [1:0]       sync;
    logic             rxs;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [5:0]       lcr_q;
    logic             par_bit;

    logic             pen;
    logic [2:0]       last_bit;
    logic             exp_par;
    logic             commit;
    logic [7:0]       new_data;
    logic             new_pe;
    logic             new_fe;
    logic             new_bi;
    logic             unused_stb;

    assign rxs        = sync[1];
    assign pen        = lcr_q[LCR_PEN];
    assign last_bit   = 3'd4 + {1'b0, lcr_q[LCR_WLS_MSB:LCR_WLS_LSB]};
    assign rx_busy_o  = (state != ST_IDLE);
    assign commit     = baud_tick_i && (state == ST_STOP) && (cnt == LAST_CNT);
    assign unused_stb = lcr_q[LCR_STB];

    // Two-flop synchroniser for the asynchronous serial line
    // NOTE: clocked state always uses <=, so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) sync <= 2'b11;
        else       sync <= {sync[0], rxd_i};
    end

    // Character status derived at the stop-bit sample point
    // NOTE: every output gets a default at the top so no path can infer a latch.
    always_comb begin
        exp_par  = 1'b0;
        new_pe   = 1'b0;
        new_fe   = 1'b0;
        new_bi   = 1'b0;
        new_data = shreg;
        // shreg is cleared at the start, so its unused upper bits do not disturb the XOR
        if (lcr_q[LCR_STICK]) exp_par = ~lcr_q[LCR_EPS];
        else if (lcr_q[LCR_EPS]) exp_par = ^shreg;
        else exp_par = ~^shreg;
        new_pe = pen && (par_bit != exp_par);
        new_fe = !rxs;
        new_bi = (shreg == 8'h00) && (!pen || !par_bit) && !rxs;
        if (new_bi) new_data = 8'h00;
    end

    // Receive FSM: start validation, data/parity/stop sampling, break hold-off
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            lcr_q   <= '0;
            par_bit <= 1'b0;
        end else if (baud_tick_i) begin
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == MID_CNT) begin
                        if (rxs) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            cnt     <= '0;
                            bit_cnt <= '0;
                            shreg   <= '0;
                            lcr_q   <= lcr_i;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt            <= '0;
                        shreg[bit_cnt] <= rxs;
                        if (bit_cnt == last_bit) state <= pen ? ST_PARITY : ST_STOP;
                        else                     bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt     <= '0;
                        par_bit <= rxs;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop lets a back-to-back start edge be caught
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        state <= new_bi ? ST_BRKWAIT : ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BRKWAIT: begin
                    if (rxs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [10:0] fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        head_evt;
    logic        head_evt_q;
    logic        oe_q;
    logic        pe_q;
    logic        fe_q;
    logic        bi_q;

    uart_8250_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (11)
    ) u_fifo (
        .clk   (CLK_I),
        .rst   (RST_I),
        .push  (commit),
        .pop   (rbr_pop_i),
        .wdata ({new_bi, new_fe, new_pe, new_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The head entry changes on an accepted pop or a push into an empty FIFO
    assign head_evt = (rbr_pop_i && !fifo_empty) || (commit && fifo_empty);

    assign rbr_o = fifo_empty ? 8'h00 : fifo_rdata[7:0];
    assign dr_o  = !fifo_empty;
    assign oe_o  = oe_q;
    assign pe_o  = pe_q;
    assign fe_o  = fe_q;
    assign bi_o  = bi_q;

    // Sticky status: head flags latch one cycle after the head changes; set beats clear
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            head_evt_q <= 1'b0;
            oe_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            bi_q       <= 1'b0;
        end else begin
            head_evt_q <= head_evt;
            if (lsr_clr_i) begin
                oe_q <= 1'b0;
                pe_q <= 1'b0;
                fe_q <= 1'b0;
                bi_q <= 1'b0;
            end
            if (head_evt_q && !fifo_empty) begin
                pe_q <= fifo_rdata[8];
                fe_q <= fifo_rdata[9];
                bi_q <= fifo_rdata[10];
            end
            if (commit && fifo_full && !rbr_pop_i) oe_q <= 1'b1;
        end
    end
`else
    logic [7:0] rbr_q;
    logic       dr_q;
    logic       oe_q;
    logic       pe_q;
    logic       fe_q;
    logic       bi_q;

    assign rbr_o = rbr_q;
    assign dr_o  = dr_q;
    assign oe_o  = oe_q;
    assign pe_o  = pe_q;
    assign fe_o  = fe_q;
    assign bi_o  = bi_q;

    // Holding register: commit overwrites, later assignments win so set beats clear
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rbr_q <= '0;
            dr_q  <= 1'b0;
            oe_q  <= 1'b0;
            pe_q  <= 1'b0;
            fe_q  <= 1'b0;
            bi_q  <= 1'b0;
        end else begin
            if (lsr_clr_i) begin
                oe_q <= 1'b0;
                pe_q <= 1'b0;
                fe_q <= 1'b0;
                bi_q <= 1'b0;
            end
            if (commit) begin
                rbr_q <= new_data;
                pe_q  <= new_pe;
                fe_q  <= new_fe;
                bi_q  <= new_bi;
                dr_q  <= 1'b1;
                if (dr_q && !rbr_pop_i) oe_q <= 1'b1;
            end else if (rbr_pop_i) begin
                dr_q <= 1'b0;
            end
        end
    end
`endif

endmodule
